pe_feeder: RTL and testbench

- Transmit side of the PE load interface.
- On a start pulse, reads 3 weight words and 32 ifmap words from a local buffer through a read port with 1-cycle read latency.
- Pushes the words into one PE over the shared value bus, using the weight_wea and ifmap_wea strobes.
- Waits for the PE to acknowledge the full load by dropping its Ready, then reports done or timeout.

---
 rtl/pe_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_pe_feeder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: reads weight and ifmap words from a local buffer and pushes them into one PE,
// then waits for the PE to acknowledge the load by dropping Ready (or times out).
module pe_feeder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int N_WEIGHT = 3,
  parameter int N_IFMAP  = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] i_base,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pe_ena,
  output logic              pe_weight_wea,
  output logic              pe_ifmap_wea,
  output logic              pe_psum_wea,
  output logic [DATA_W-1:0] pe_value,
  input  logic              pe_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N_MAX  = (N_IFMAP > N_WEIGHT) ? N_IFMAP : N_WEIGHT;
  localparam int CNT_W  = $clog2(N_MAX) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;

  localparam logic [CNT_W-1:0]  LAST_W   = CNT_W'(N_WEIGHT - 1);
  localparam logic [CNT_W-1:0]  LAST_I   = CNT_W'(N_IFMAP - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ENABLE, S_FEED_W, S_FEED_I, S_DRAIN, S_WAIT_ACK, S_DONE, S_ERR
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [ADDR_W-1:0]   i_base_reg, i_base_next;
  logic                ack_reg, ack_next;
  logic                pe_ena_reg, pe_ena_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                rd_issue;

  // Read pipeline: valid/tag follow each read by one cycle, push registers by two.
  logic                rd_vld_reg;
  logic                rd_tag_reg;
  logic                weight_wea_reg;
  logic                ifmap_wea_reg;
  logic [DATA_W-1:0]   value_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wait_next     = wait_reg;
    mem_addr_next = mem_addr_reg;
    i_base_next   = i_base_reg;
    ack_next      = ack_reg;
    pe_ena_next   = pe_ena_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    rd_issue      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_ENABLE;
          busy_next     = 1'b1;
          // A PE still enabled from the previous load gets one low cycle to restart cleanly.
          pe_ena_next   = ~pe_ena_reg;
          mem_addr_next = w_base;
          i_base_next   = i_base;
          ack_next      = 1'b0;
          cnt_next      = '0;
        end
      end

      S_ENABLE: begin
        pe_ena_next = 1'b1;
        if (pe_ena_reg && pe_ready) begin
          state_next = S_FEED_W;
        end
      end

      S_FEED_W: begin
        if (pe_ready) begin
          rd_issue = 1'b1;
          if (cnt_reg == LAST_W) begin
            cnt_next      = '0;
            mem_addr_next = i_base_reg;
            state_next    = S_FEED_I;
          end else begin
            cnt_next      = cnt_reg + CNT_W'(1);
            mem_addr_next = mem_addr_reg + ADDR_W'(1);
          end
        end else begin
          ack_next = 1'b1;
        end
      end

      S_FEED_I: begin
        if (pe_ready) begin
          rd_issue      = 1'b1;
          mem_addr_next = mem_addr_reg + ADDR_W'(1);
          if (cnt_reg == LAST_I) begin
            cnt_next   = '0;
            state_next = S_DRAIN;
          end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end else begin
          ack_next = 1'b1;
        end
      end

      S_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          cnt_next   = '0;
          wait_next  = '0;
          state_next = S_WAIT_ACK;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
        end
      end

      S_WAIT_ACK: begin
        if (!pe_ready || ack_reg) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else if (wait_reg == WAIT_MAX) begin
          state_next  = S_ERR;
          err_next    = 1'b1;
          pe_ena_next = 1'b0;
        end else begin
          wait_next   = wait_reg + WAIT_W'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end

      S_ERR: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      wait_reg       <= '0;
      mem_addr_reg   <= '0;
      i_base_reg     <= '0;
      ack_reg        <= 1'b0;
      pe_ena_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      rd_vld_reg     <= 1'b0;
      rd_tag_reg     <= 1'b0;
      weight_wea_reg <= 1'b0;
      ifmap_wea_reg  <= 1'b0;
      value_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      wait_reg       <= wait_next;
      mem_addr_reg   <= mem_addr_next;
      i_base_reg     <= i_base_next;
      ack_reg        <= ack_next;
      pe_ena_reg     <= pe_ena_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      rd_vld_reg     <= rd_issue;
      rd_tag_reg     <= (state_reg == S_FEED_W);
      weight_wea_reg <= rd_vld_reg & rd_tag_reg;
      ifmap_wea_reg  <= rd_vld_reg & ~rd_tag_reg;
      if (rd_vld_reg) begin
        value_reg    <= mem_rdata;
      end
    end
  end

  // Read enable follows the live Ready so a stalled cycle never issues a read.
  assign mem_rd        = rd_issue;
  assign mem_addr      = mem_addr_reg;
  assign pe_ena        = pe_ena_reg;
  assign pe_weight_wea = weight_wea_reg;
  assign pe_ifmap_wea  = ifmap_wea_reg;
  assign pe_psum_wea   = 1'b0;
  assign pe_value      = value_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_pe_feeder.sv
// Testbench for pe_feeder: buffer and PE behavioural models, scoreboard of expected
// reads and pushes computed from base addresses and buffer contents.
module tb_pe_feeder;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int NW     = 3;
  localparam int NI     = 32;
  localparam int TO     = 255;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NTOT   = NW + NI;

  typedef struct {
    logic              is_w;
    logic [DATA_W-1:0] val;
  } push_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] w_base = '0;
  logic [ADDR_W-1:0] i_base = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              pe_ena, pe_weight_wea, pe_ifmap_wea, pe_psum_wea;
  logic [DATA_W-1:0] pe_value;
  logic              pe_ready;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] exp_addr [$];
  push_t             exp_push [$];
  int                rd_cyc [$];

  int  cyc = 0;
  int  n_rd, n_push, n_done, n_err, first_push, last_push, err_cyc;
  bit  have_last, prev_end, ena_high;
  logic [DATA_W-1:0] last_val;
  logic [ADDR_W-1:0] mon_ea;
  push_t             mon_ep;
  int                mon_rc;

  logic hold_rdy = 1'b0;
  logic stall = 1'b0;
  int   pe_wn, pe_in;
  logic pe_rdy_q;

  always #5 clk = ~clk;

  pe_feeder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_WEIGHT(NW), .N_IFMAP(NI), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .w_base(w_base), .i_base(i_base),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pe_ena(pe_ena), .pe_weight_wea(pe_weight_wea), .pe_ifmap_wea(pe_ifmap_wea),
    .pe_psum_wea(pe_psum_wea), .pe_value(pe_value), .pe_ready(pe_ready),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_pe_ena"}, pe_ena, 0);
    check({tag, "_weight_wea"}, pe_weight_wea, 0);
    check({tag, "_ifmap_wea"}, pe_ifmap_wea, 0);
    check({tag, "_psum_wea"}, pe_psum_wea, 0);
    check({tag, "_pe_value"}, pe_value, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Buffer with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // PE: Ready rises once enabled, drops two cycles after both FIFOs are full.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pe_rdy_q <= 1'b0; pe_wn <= 0; pe_in <= 0;
    end else if (!pe_ena) begin
      pe_rdy_q <= 1'b0; pe_wn <= 0; pe_in <= 0;
    end else begin
      if (pe_weight_wea) pe_wn <= pe_wn + 1;
      if (pe_ifmap_wea)  pe_in <= pe_in + 1;
      pe_rdy_q <= hold_rdy || !(pe_wn >= NW && pe_in >= NI);
    end
  end
  assign pe_ready = pe_rdy_q & ~stall;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      prev_end = 1'b0;
    end else begin
      if (prev_end) begin
        check("busy_fall", busy, 0);
        prev_end = 1'b0;
      end
      if (mem_rd) begin
        check("rd_ready", pe_ready, 1);
        mon_ea = 'x;
        if (exp_addr.size() > 0) mon_ea = exp_addr.pop_front();
        check("rd_addr", mem_addr, mon_ea);
        rd_cyc.push_back(cyc);
        n_rd++;
      end
      if (pe_weight_wea || pe_ifmap_wea) begin
        check("strobe_excl", pe_weight_wea & pe_ifmap_wea, 0);
        check("psum_zero", pe_psum_wea, 0);
        mon_ep.is_w = 1'bx;
        mon_ep.val  = 'x;
        if (exp_push.size() > 0) mon_ep = exp_push.pop_front();
        check("push_kind", pe_weight_wea, mon_ep.is_w);
        check("push_val", pe_value, mon_ep.val);
        mon_rc = -100;
        if (rd_cyc.size() > 0) mon_rc = rd_cyc.pop_front();
        check("push_lat", cyc - mon_rc, 2);
        if (n_push == 0) first_push = cyc;
        last_push = cyc;
        n_push++;
        last_val  = pe_value;
        have_last = 1'b1;
      end else if (have_last) begin
        check("value_hold", pe_value, last_val);
      end
      if (done) begin
        n_done++;
        check("done_ena", pe_ena, 1);
        check("done_busy", busy, 1);
        prev_end = 1'b1;
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
        check("err_ena", pe_ena, 0);
        check("err_busy", busy, 1);
        prev_end = 1'b1;
      end
    end
  end

  task automatic do_load(input string name, input logic [ADDR_W-1:0] wb,
                         input logic [ADDR_W-1:0] ib, input int stall_at,
                         input int stall_len, input bit to_mode, input bit poke,
                         input bit rst_mid);
    int    g;
    int    a;
    push_t p;
    exp_addr.delete(); exp_push.delete(); rd_cyc.delete();
    n_rd = 0; n_push = 0; n_done = 0; n_err = 0; have_last = 1'b0;
    for (int k = 0; k < NW; k++) begin
      a = (int'(wb) + k) % DEPTH;
      exp_addr.push_back(ADDR_W'(a));
      p.is_w = 1'b1; p.val = mem[a];
      exp_push.push_back(p);
    end
    for (int k = 0; k < NI; k++) begin
      a = (int'(ib) + k) % DEPTH;
      exp_addr.push_back(ADDR_W'(a));
      p.is_w = 1'b0; p.val = mem[a];
      exp_push.push_back(p);
    end

    hold_rdy = to_mode;
    @(posedge clk); #1;
    check("idle_before_start", busy, 0);
    w_base = wb; i_base = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w_base = ADDR_W'($urandom); i_base = ADDR_W'($urandom);
    check("busy_after_start", busy, 1);
    check("ena_on_entry", pe_ena, ena_high ? 0 : 1);
    @(posedge clk); #1;
    check("ena_after_entry", pe_ena, 1);

    if (stall_len > 0) begin
      g = 0;
      while (n_rd < NW + stall_at && g < 500) begin
        @(posedge clk); #1; g++;
      end
      check("stall_reach", g < 500, 1);
      stall = 1'b1;
      for (int s = 0; s < stall_len; s++) begin
        #1 check("stall_no_rd", mem_rd, 0);
        @(posedge clk); #1;
      end
      stall = 1'b0;
    end

    if (poke) begin
      g = 0;
      while (n_rd < NW + 6 && g < 500) begin
        @(posedge clk); #1; g++;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end

    if (rst_mid) begin
      g = 0;
      while (!(pe_ifmap_wea && n_push == NW + 4) && g < 500) begin
        @(posedge clk); #1; g++;
      end
      check("rst_reach", g < 500, 1);
      #2 rstn = 1'b0;
      #1 check_quiet("rst_mid");
      exp_addr.delete(); exp_push.delete(); rd_cyc.delete();
      have_last = 1'b0; hold_rdy = 1'b0;
      repeat (2) @(negedge clk);
      #1 rstn = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        check("post_rst_quiet", {mem_rd, pe_weight_wea, pe_ifmap_wea, pe_ena, busy}, 0);
      end
      ena_high = 1'b0;
      $display("load %-10s wb=%03h ib=%03h aborted by reset after %0d pushes", name, wb, ib, n_push);
      return;
    end

    g = 0;
    while (!(done || err) && g < 2000) begin
      @(negedge clk); g++;
    end
    check("finish_in_time", g < 2000, 1);
    if (poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (poke ? 20 : 4) @(negedge clk);

    check("n_reads", n_rd, NTOT);
    check("n_pushes", n_push, NTOT);
    check("pushes_left", exp_push.size(), 0);
    check("n_done", n_done, to_mode ? 0 : 1);
    check("n_err", n_err, to_mode ? 1 : 0);
    check("busy_end", busy, 0);
    if (stall_len == 0) check("contiguous", last_push - first_push, NTOT - 1);
    if (to_mode) check("timeout_at", err_cyc - last_push, 1 + TO + 1);
    hold_rdy = 1'b0;
    ena_high = !to_mode;
    $display("load %-10s wb=%03h ib=%03h reads=%0d pushes=%0d done=%0d err=%0d",
             name, wb, ib, n_rd, n_push, n_done, n_err);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
    for (int k = 0; k < NW; k++) mem[16 + k] = DATA_W'(k + 1);
    for (int k = 0; k < NI; k++) mem[32 + k] = DATA_W'(32'h100 + k);
    ena_high = 1'b0;

    #2 rstn = 1'b0;
    #1 check_quiet("reset");
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);

    do_load("basic",      10'h010, 10'h020, 0, 0, 1'b0, 1'b0, 1'b0);
    do_load("stall",      10'h010, 10'h020, 10, 4, 1'b0, 1'b0, 1'b0);
    do_load("timeout",    10'h040, 10'h080, 0, 0, 1'b1, 1'b0, 1'b0);
    do_load("wrap",       10'h100, 10'h3F0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_load("busy_start", ADDR_W'($urandom), ADDR_W'($urandom), 0, 0, 1'b0, 1'b1, 1'b0);
    do_load("second",     ADDR_W'($urandom), ADDR_W'($urandom), 0, 0, 1'b0, 1'b0, 1'b0);
    do_load("reset_mid",  ADDR_W'($urandom), ADDR_W'($urandom), 0, 0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1)
        do_load("random", ADDR_W'($urandom), ADDR_W'($urandom),
                int'($urandom_range(1, 28)), int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);
      else
        do_load("random", ADDR_W'($urandom), ADDR_W'($urandom), 0, 0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
